mandelbrot_render: RTL

- Frame-walking controller that sits directly upstream of the fixed-point Mandelbrot iteration engine.
- Scans an H_RES x V_RES frame in raster order and derives each pixel's complex coordinate incrementally, using adders only.
- Starts the engine for each pixel, waits for it to finish, then writes the iteration count to the framebuffer write port.
- Runs one pixel at a time; the engine is never overlapped.

---
 rtl/mandelbrot_render.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/mandelbrot_render.sv
// Raster-order frame walker for the Mandelbrot engine: steps the complex coordinate
// per pixel with adders only, runs one engine job at a time, writes counts to the framebuffer.
module mandelbrot_render #(
  parameter int FP_WIDTH = 25,
  parameter int FP_INT   = 4,
  parameter int ITERW    = 8,
  parameter int H_RES    = 320,
  parameter int V_RES    = 180,
  parameter int ADDRW    = $clog2(H_RES*V_RES)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic signed [FP_WIDTH-1:0] re_start,
  input  logic signed [FP_WIDTH-1:0] im_start,
  input  logic signed [FP_WIDTH-1:0] step,
  output logic                       busy,
  output logic                       done,
  output logic                       eng_start,
  output logic signed [FP_WIDTH-1:0] eng_re,
  output logic signed [FP_WIDTH-1:0] eng_im,
  input  logic                       eng_done,
  input  logic [ITERW-1:0]           eng_iter,
  output logic                       fb_we,
  output logic [ADDRW-1:0]           fb_addr,
  output logic [ITERW-1:0]           fb_data
);

  localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);

  // The fixed-point split belongs to the engine; an out-of-range split shows up as this scope.
  if (FP_INT >= FP_WIDTH) begin : g_fp_int_out_of_range
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FINISH} state_t;

  state_t                state_q, state_d;
  logic                  busy_d, done_d, eng_start_d, fb_we_d;
  logic [ADDRW-1:0]      fb_addr_d, addr_q, addr_d;
  logic [ITERW-1:0]      fb_data_d;
  logic signed [FP_WIDTH-1:0] eng_re_d, eng_im_d;
  logic signed [FP_WIDTH-1:0] re0_q, re0_d, step_q, step_d;
  logic [XW-1:0]         x_q, x_d;
  logic [YW-1:0]         y_q, y_d;
  logic                  last_px;

  assign last_px = (x_q == X_LAST) && (y_q == Y_LAST);

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    state_d     = state_q;
    busy_d      = busy;
    done_d      = 1'b0;
    eng_start_d = 1'b0;
    fb_we_d     = 1'b0;
    fb_addr_d   = fb_addr;
    fb_data_d   = fb_data;
    eng_re_d    = eng_re;
    eng_im_d    = eng_im;
    x_d         = x_q;
    y_d         = y_q;
    addr_d      = addr_q;
    re0_d       = re0_q;
    step_d      = step_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          re0_d    = re_start;
          step_d   = step;
          eng_re_d = re_start;
          eng_im_d = im_start;
          x_d      = '0;
          y_d      = '0;
          addr_d   = '0;
          busy_d   = 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        eng_start_d = 1'b1;
        state_d     = WAIT;
      end
      WAIT: begin
        if (eng_done) begin
          fb_we_d   = 1'b1;
          fb_data_d = eng_iter;
          fb_addr_d = addr_q;
          addr_d    = addr_q + ADDRW'(1);
          // Screen y grows downward, so a row wrap lowers the imaginary part.
          if (x_q != X_LAST) begin
            x_d      = x_q + XW'(1);
            eng_re_d = eng_re + step_q;
          end else begin
            x_d      = '0;
            eng_re_d = re0_q;
            y_d      = y_q + YW'(1);
            eng_im_d = eng_im - step_q;
          end
          state_d = last_px ? FINISH : ISSUE;
        end
      end
      FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      eng_start <= 1'b0;
      fb_we     <= 1'b0;
      fb_addr   <= '0;
      fb_data   <= '0;
      eng_re    <= '0;
      eng_im    <= '0;
      x_q       <= '0;
      y_q       <= '0;
      addr_q    <= '0;
      re0_q     <= '0;
      step_q    <= '0;
    end else begin
      state_q   <= state_d;
      busy      <= busy_d;
      done      <= done_d;
      eng_start <= eng_start_d;
      fb_we     <= fb_we_d;
      fb_addr   <= fb_addr_d;
      fb_data   <= fb_data_d;
      eng_re    <= eng_re_d;
      eng_im    <= eng_im_d;
      x_q       <= x_d;
      y_q       <= y_d;
      addr_q    <= addr_d;
      re0_q     <= re0_d;
      step_q    <= step_d;
    end
  end

endmodule
